// File: rtl/vec_pipe_pkg.sv
// Shared types for the vector pipeline hazard logic.
//   sb_entry_t : one scoreboard stage (producer info plus the operand info of
//                the instruction sitting in that stage)
//   fwd_sel_t  : widest forwarding select (DEPTH up to 8 -> 3 bits)
//   BUBBLE     : empty stage
//   lane_match : does a stage write a given register in a given lane
// Struct fields are sized for the largest supported configuration.
// Narrower instances zero-extend addresses and masks into them.
package vec_pipe_pkg;

    localparam int SB_WA_MAX = 8;   // widest RF address supported
    localparam int SB_WV_MAX = 64;  // most lanes supported
    localparam int SB_WS_MAX = 3;   // select width for DEPTH = 8

    typedef logic [SB_WS_MAX-1:0] fwd_sel_t;

    typedef struct packed {
        logic                 valid;
        logic [SB_WA_MAX-1:0] dst;
        logic [SB_WV_MAX-1:0] we;
        logic                 is_load;
        logic [SB_WA_MAX-1:0] src_a;
        logic [SB_WA_MAX-1:0] src_b;
        logic                 use_a;
        logic                 use_b;
    } sb_entry_t;

    localparam sb_entry_t BUBBLE = '0;

    // A stage matches when it is live, targets the register being read and
    // actually writes this lane. A zero lane mask therefore never matches.
    function automatic logic lane_match(input sb_entry_t e,
                                        input logic [SB_WA_MAX-1:0] src,
                                        input logic [5:0] lane);
        return e.valid && (e.dst == src) && e.we[lane];
    endfunction

endpackage

// File: rtl/vec_hazard_unit_fwd_prio_enc.sv
// Per-lane forwarding priority encoder.
// Ports:
//   match : bit k set when scoreboard stage k (1..DEPTH-1) supplies this lane
//   sel   : smallest set k (the newest producer), 0 when nothing matches
module fwd_prio_enc #(
    parameter  int DEPTH = 3,
    localparam int WS    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:1] match,
    output logic [WS-1:0]    sel
);

    // Walk from the oldest stage towards the newest so that the youngest
    // matching stage overwrites any older one.
    always_comb begin
        sel = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (match[k]) begin
                sel = WS'(k);
            end
        end
    end

endmodule

// File: rtl/vec_hazard_unit.sv
// Hazard and forwarding controller for the vector pipeline.
// It keeps a DEPTH-stage scoreboard of in-flight RF writes (S0 = EXE ...
// S(DEPTH-1) = WB). It produces per-lane operand forwarding selects for the
// instruction in S0 and a load-use stall for the instruction in decode.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   adv                  pipeline advance; nothing moves while low
//   flush                taken jump: kill decode slot and the S0 instruction
//   dec_valid            decode slot holds an instruction
//   dec_src_a/b          operand addresses
//   dec_use_a/b          operand is actually read
//   dec_dst, dec_we      destination address and lane write mask
//   dec_is_load          destination data arrives from memory
//   stall                hold fetch/decode this cycle
//   fwd_sel_a/b          per-lane select, WS bits per lane: 0 = RF, k = stage k
//   stall_cnt, cnt_clr   saturating stall-cycle counter and its sync clear
module vec_hazard_unit
    import vec_pipe_pkg::*;
#(
    parameter  int WA_RF        = 4,
    parameter  int WIDTH_VECTOR = 16,
    parameter  int DEPTH        = 3,
    parameter  int LOAD_LAT     = 1,
    localparam int WS           = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       adv,
    input  logic                       flush,
    input  logic                       dec_valid,
    input  logic [WA_RF-1:0]           dec_src_a,
    input  logic [WA_RF-1:0]           dec_src_b,
    input  logic                       dec_use_a,
    input  logic                       dec_use_b,
    input  logic [WA_RF-1:0]           dec_dst,
    input  logic [WIDTH_VECTOR-1:0]    dec_we,
    input  logic                       dec_is_load,
    output logic                       stall,
    output logic [WIDTH_VECTOR*WS-1:0] fwd_sel_a,
    output logic [WIDTH_VECTOR*WS-1:0] fwd_sel_b,
    output logic [15:0]                stall_cnt,
    input  logic                       cnt_clr
);

    sb_entry_t   sb_reg  [DEPTH];
    sb_entry_t   sb_next [DEPTH];
    sb_entry_t   dec_entry;
    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;

    // Decode slot packed into scoreboard form (zero-extended into the struct).
    always_comb begin
        dec_entry         = BUBBLE;
        dec_entry.valid   = 1'b1;
        dec_entry.dst     = SB_WA_MAX'(dec_dst);
        dec_entry.we      = SB_WV_MAX'(dec_we);
        dec_entry.is_load = dec_is_load;
        dec_entry.src_a   = SB_WA_MAX'(dec_src_a);
        dec_entry.src_b   = SB_WA_MAX'(dec_src_b);
        dec_entry.use_a   = dec_use_a;
        dec_entry.use_b   = dec_use_b;
    end

    // ------------------------------------------------------------------
    // Load-use stall: a load whose data is not yet forwardable (stages
    // below LOAD_LAT) writing any lane the decoded instruction reads.
    // ------------------------------------------------------------------
    logic [LOAD_LAT-1:0] ld_hit;

    genvar gi, gj;
    generate
        for (gi = 0; gi < LOAD_LAT; gi++) begin : g_ld_stage
            logic [WIDTH_VECTOR-1:0] lane_hit;
            for (gj = 0; gj < WIDTH_VECTOR; gj++) begin : g_ld_lane
                assign lane_hit[gj] = sb_reg[gi].is_load &&
                    ((dec_use_a && lane_match(sb_reg[gi], dec_entry.src_a, 6'(gj))) ||
                     (dec_use_b && lane_match(sb_reg[gi], dec_entry.src_b, 6'(gj))));
            end
            assign ld_hit[gi] = |lane_hit;
        end
    endgenerate

    // A flushed decode slot is discarded anyway, so it must not hold the pipe.
    assign stall = dec_valid && !flush && (|ld_hit);

    // ------------------------------------------------------------------
    // Per-lane forwarding for the S0 operands. Only stages 1..DEPTH-1 are
    // candidates; S0 never forwards to itself, so dst==src inside one
    // instruction reads the older value.
    // ------------------------------------------------------------------
    logic s0_rd_a;
    logic s0_rd_b;

    assign s0_rd_a = sb_reg[0].valid && sb_reg[0].use_a;
    assign s0_rd_b = sb_reg[0].valid && sb_reg[0].use_b;

    generate
        for (gi = 0; gi < WIDTH_VECTOR; gi++) begin : g_lane
            logic [DEPTH-1:1] match_a;
            logic [DEPTH-1:1] match_b;
            for (gj = 1; gj < DEPTH; gj++) begin : g_stage
                assign match_a[gj] = s0_rd_a && lane_match(sb_reg[gj], sb_reg[0].src_a, 6'(gi));
                assign match_b[gj] = s0_rd_b && lane_match(sb_reg[gj], sb_reg[0].src_b, 6'(gi));
            end

            fwd_prio_enc #(.DEPTH(DEPTH)) u_enc_a (
                .match (match_a),
                .sel   (fwd_sel_a[gi*WS +: WS])
            );

            fwd_prio_enc #(.DEPTH(DEPTH)) u_enc_b (
                .match (match_b),
                .sel   (fwd_sel_b[gi*WS +: WS])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scoreboard shift register. A flush kills the instruction currently in
    // S0, so the slot it moves into (S1) becomes a bubble as well.
    // ------------------------------------------------------------------
    always_comb begin
        sb_next = sb_reg;
        if (adv) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb_next[k] = sb_reg[k-1];
            end
            if (flush) begin
                sb_next[1] = BUBBLE;
            end
            if (flush || stall || !dec_valid) begin
                sb_next[0] = BUBBLE;
            end else begin
                sb_next[0] = dec_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_reg[k] <= BUBBLE;
            end
        end else begin
            sb_reg <= sb_next;
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle counter: counts cycles where the pipe advanced around a
    // stall, saturates, and the clear takes precedence over counting.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (stall && adv && (cnt_reg != 16'hFFFF)) begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_vec_hazard_unit.sv
// Bench for vec_hazard_unit (DEPTH=3, LOAD_LAT=1, 16 lanes).
// A reference model keeps the in-flight instructions as a small array,
// oldest at the highest index, and derives stall/forwarding from the rules.
module tb_vec_hazard_unit;

    localparam int WA_RF    = 4;
    localparam int WV       = 16;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int WS       = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic              adv;
    logic              flush;
    logic              dec_valid;
    logic [WA_RF-1:0]  dec_src_a;
    logic [WA_RF-1:0]  dec_src_b;
    logic              dec_use_a;
    logic              dec_use_b;
    logic [WA_RF-1:0]  dec_dst;
    logic [WV-1:0]     dec_we;
    logic              dec_is_load;
    logic              stall;
    logic [WV*WS-1:0]  fwd_sel_a;
    logic [WV*WS-1:0]  fwd_sel_b;
    logic [15:0]       stall_cnt;
    logic              cnt_clr;

    always #5 clk = ~clk;

    vec_hazard_unit #(
        .WA_RF(WA_RF), .WIDTH_VECTOR(WV), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk(clk), .rstn(rstn), .adv(adv), .flush(flush),
        .dec_valid(dec_valid), .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
        .dec_use_a(dec_use_a), .dec_use_b(dec_use_b), .dec_dst(dec_dst),
        .dec_we(dec_we), .dec_is_load(dec_is_load), .stall(stall),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
    );

    typedef struct {
        bit          valid;
        int          dst;
        bit [WV-1:0] we;
        bit          ld;
        int          sa;
        int          sb;
        bit          ua;
        bit          ub;
    } instr_t;

    instr_t pipe [DEPTH];
    int     exp_cnt;
    int     n_vec = 0;
    int     n_err = 0;

    // ---------------- reference model ----------------
    function automatic instr_t bubble();
        instr_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic instr_t cur_dec();
        instr_t d;
        d.valid = 1'b1;
        d.dst = int'(dec_dst);
        d.we = dec_we;
        d.ld = dec_is_load;
        d.sa = int'(dec_src_a);
        d.sb = int'(dec_src_b);
        d.ua = dec_use_a;
        d.ub = dec_use_b;
        return d;
    endfunction

    // A load not yet past stage LOAD_LAT-1 that writes anything the decoded
    // instruction reads forces a stall (unless the slot is being flushed).
    function automatic bit model_stall();
        if (!dec_valid || flush) return 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (pipe[k].valid && pipe[k].ld && pipe[k].we != 0 &&
                ((dec_use_a && pipe[k].dst == int'(dec_src_a)) ||
                 (dec_use_b && pipe[k].dst == int'(dec_src_b))))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Newest older instruction writing the lane supplies it; else the RF.
    function automatic logic [WV*WS-1:0] model_sel(input bit side_b);
        logic [WV*WS-1:0] r;
        int src;
        bit u;
        r = '0;
        src = side_b ? pipe[0].sb : pipe[0].sa;
        u = side_b ? pipe[0].ub : pipe[0].ua;
        if (!pipe[0].valid || !u) return r;
        for (int lane = 0; lane < WV; lane++) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (pipe[k].valid && pipe[k].dst == src && pipe[k].we[lane]) begin
                    r[lane*WS +: WS] = WS'(k);
                    break;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [WV*WS-1:0] fill(input int v);
        logic [WV*WS-1:0] r;
        for (int lane = 0; lane < WV; lane++) r[lane*WS +: WS] = WS'(v);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) pipe[k] = bubble();
        exp_cnt = 0;
    endtask

    // One clock: model follows the edge using the inputs held across it.
    task automatic tick();
        bit st;
        instr_t d;
        st = model_stall();
        d = cur_dec();
        @(posedge clk);
        if (cnt_clr) exp_cnt = 0;
        else if (adv && st && exp_cnt < 65535) exp_cnt++;
        if (adv) begin
            for (int k = DEPTH - 1; k >= 1; k--) pipe[k] = pipe[k-1];
            if (flush) pipe[1] = bubble();
            if (flush || st || !dec_valid) pipe[0] = bubble();
            else pipe[0] = d;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int sa, input bit ua, input int sb, input bit ub,
                         input int dst, input logic [WV-1:0] we, input bit ld);
        dec_valid = v;
        dec_src_a = WA_RF'(sa);
        dec_use_a = ua;
        dec_src_b = WA_RF'(sb);
        dec_use_b = ub;
        dec_dst = WA_RF'(dst);
        dec_we = we;
        dec_is_load = ld;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, '0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0;
        adv = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        drive(1, 3, 1, 3, 1, 3, 16'hFFFF, 1);
        model_reset();
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b want 0", stall); end
        n_vec++; if (fwd_sel_a !== '0) begin n_err++; $display("FAIL reset_fwd_a: got %h want 0", fwd_sel_a); end
        n_vec++; if (fwd_sel_b !== '0) begin n_err++; $display("FAIL reset_fwd_b: got %h want 0", fwd_sel_b); end
        n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        idle(1);
        $display("test_reset done");
    endtask

    task automatic test_alu_fwd();
        drive(1, 0, 0, 0, 0, 3, 16'hFFFF, 0);
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall_w: got %0b want 0", stall); end
        tick();
        drive(1, 3, 1, 0, 0, 8, 16'hFFFF, 0);
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall_r: got %0b want 0", stall); end
        tick();
        n_vec++; if (fwd_sel_a !== fill(1)) begin n_err++; $display("FAIL alu_fwd1: got %h want %h", fwd_sel_a, fill(1)); end
        n_vec++; if (fwd_sel_b !== '0) begin n_err++; $display("FAIL alu_fwd1_b: got %h want 0", fwd_sel_b); end
        drive(1, 0, 0, 0, 0, 3, 16'hFFFF, 0);
        tick();
        drive(1, 0, 0, 0, 0, 9, 16'hFFFF, 0);
        tick();
        drive(1, 3, 1, 3, 1, 10, 16'hFFFF, 0);
        tick();
        n_vec++; if (fwd_sel_a !== fill(2)) begin n_err++; $display("FAIL alu_fwd2_a: got %h want %h", fwd_sel_a, fill(2)); end
        n_vec++; if (fwd_sel_b !== fill(2)) begin n_err++; $display("FAIL alu_fwd2_b: got %h want %h", fwd_sel_b, fill(2)); end
        $display("test_alu_fwd done");
    endtask

    task automatic test_partial_lanes();
        logic [WV*WS-1:0] want;
        idle(3);
        drive(1, 0, 0, 0, 0, 3, 16'h00FF, 0);
        tick();
        drive(1, 0, 0, 0, 0, 3, 16'h0F0F, 0);
        tick();
        drive(1, 0, 0, 3, 1, 11, 16'hFFFF, 0);
        tick();
        for (int lane = 0; lane < WV; lane++)
            want[lane*WS +: WS] = (lane < 4 || (lane >= 8 && lane < 12)) ? 2'd1 : (lane < 8 ? 2'd2 : 2'd0);
        n_vec++; if (fwd_sel_b !== want) begin n_err++; $display("FAIL partial_b: got %h want %h", fwd_sel_b, want); end
        n_vec++; if (fwd_sel_a !== '0) begin n_err++; $display("FAIL partial_a: got %h want 0", fwd_sel_a); end
        drive(1, 0, 0, 0, 0, 6, 16'h0000, 0);
        tick();
        drive(1, 6, 1, 0, 0, 12, 16'hFFFF, 0);
        tick();
        n_vec++; if (fwd_sel_a !== '0) begin n_err++; $display("FAIL zero_we: got %h want 0", fwd_sel_a); end
        $display("test_partial_lanes done");
    endtask

    task automatic test_load_use();
        idle(3);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL lu_clr: got %0d want 0", stall_cnt); end
        drive(1, 0, 0, 0, 0, 5, 16'hFFFF, 1);
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_load: got %0b want 0", stall); end
        tick();
        drive(1, 5, 1, 0, 0, 7, 16'hFFFF, 0);
        #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0b want 1", stall); end
        tick();
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_release: got %0b want 0", stall); end
        n_vec++; if (fwd_sel_a !== '0) begin n_err++; $display("FAIL lu_bubble: got %h want 0", fwd_sel_a); end
        n_vec++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
        tick();
        n_vec++; if (fwd_sel_a !== fill(2)) begin n_err++; $display("FAIL lu_fwd: got %h want %h", fwd_sel_a, fill(2)); end
        $display("test_load_use done");
    endtask

    task automatic test_flush();
        idle(3);
        drive(1, 0, 0, 0, 0, 5, 16'hFFFF, 1);
        tick();
        drive(1, 5, 1, 0, 0, 7, 16'hFFFF, 0);
        flush = 1'b1;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %0b want 0", stall); end
        tick();
        flush = 1'b0;
        #1;
        n_vec++; if (fwd_sel_a !== '0) begin n_err++; $display("FAIL fl_s0: got %h want 0", fwd_sel_a); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL fl_killed: got %0b want 0", stall); end
        tick();
        n_vec++; if (fwd_sel_a !== '0) begin n_err++; $display("FAIL fl_nofwd: got %h want 0", fwd_sel_a); end
        $display("test_flush done");
    endtask

    task automatic test_freeze();
        int c0;
        idle(3);
        drive(1, 0, 0, 0, 0, 5, 16'hFFFF, 1);
        tick();
        c0 = exp_cnt;
        drive(1, 0, 0, 5, 1, 7, 16'hFFFF, 0);
        adv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL frz_stall[%0d]: got %0b want 1", i, stall); end
            n_vec++; if (stall_cnt !== 16'(c0)) begin n_err++; $display("FAIL frz_cnt[%0d]: got %0d want %0d", i, stall_cnt, c0); end
            tick();
        end
        adv = 1'b1;
        #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL frz_end: got %0b want 1", stall); end
        tick();
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL frz_release: got %0b want 0", stall); end
        n_vec++; if (stall_cnt !== 16'(c0 + 1)) begin n_err++; $display("FAIL frz_cnt_end: got %0d want %0d", stall_cnt, c0 + 1); end
        $display("test_freeze done");
    endtask

    task automatic test_reset_mid();
        idle(3);
        for (int i = 0; i < 3; i++) begin
            drive(1, 7, 1, 7, 1, 7, 16'hFFFF, 0);
            tick();
        end
        n_vec++; if (fwd_sel_a !== fill(1)) begin n_err++; $display("FAIL rm_pre: got %h want %h", fwd_sel_a, fill(1)); end
        #2;
        rstn = 1'b0;
        #1;
        n_vec++; if (fwd_sel_a !== '0) begin n_err++; $display("FAIL rm_fwd_a: got %h want 0", fwd_sel_a); end
        n_vec++; if (fwd_sel_b !== '0) begin n_err++; $display("FAIL rm_fwd_b: got %h want 0", fwd_sel_b); end
        n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rm_cnt: got %0d want 0", stall_cnt); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        drive(1, 7, 1, 0, 0, 9, 16'hFFFF, 0);
        tick();
        n_vec++; if (fwd_sel_a !== '0) begin n_err++; $display("FAIL rm_post: got %h want 0", fwd_sel_a); end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [WV*WS-1:0] wa, wb;
        logic [WV-1:0] we;
        bit bad;
        int s;
        idle(3);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3))
                0: we = 16'hFFFF;
                1: we = 16'h0000;
                default: we = 16'($urandom);
            endcase
            drive(($urandom_range(7) != 0), $urandom_range(3), $urandom_range(1), $urandom_range(3),
                  $urandom_range(1), $urandom_range(3), we, ($urandom_range(2) == 0));
            adv = ($urandom_range(5) != 0);
            flush = ($urandom_range(9) == 0);
            cnt_clr = ($urandom_range(49) == 0);
            #1;
            wa = model_sel(1'b0);
            wb = model_sel(1'b1);
            n_vec++; if (stall !== model_stall()) begin n_err++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", i, stall, model_stall()); end
            n_vec++; if (fwd_sel_a !== wa) begin n_err++; $display("FAIL rnd_fwd_a[%0d]: got %h want %h", i, fwd_sel_a, wa); end
            n_vec++; if (fwd_sel_b !== wb) begin n_err++; $display("FAIL rnd_fwd_b[%0d]: got %h want %h", i, fwd_sel_b, wb); end
            n_vec++; if (stall_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_cnt); end
            // A not-yet-valid load must never be chosen as a forwarding source.
            bad = 1'b0;
            for (int lane = 0; lane < WV; lane++) begin
                s = int'(fwd_sel_a[lane*WS +: WS]);
                if (s != 0 && s < 1 + LOAD_LAT && pipe[s].ld) bad = 1'b1;
                s = int'(fwd_sel_b[lane*WS +: WS]);
                if (s != 0 && s < 1 + LOAD_LAT && pipe[s].ld) bad = 1'b1;
            end
            n_vec++; if (bad) begin n_err++; $display("FAIL rnd_early_load[%0d]: got early load select want none", i); end
            tick();
        end
        adv = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_partial_lanes();
        test_load_use();
        test_flush();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
